// File: rtl/smartpark_pkg.sv
// smartpark_pkg: park codes, FSM encoding and sensor constants for line_track_filter.
package smartpark_pkg;
   localparam logic [1:0] PARK_DRIVE = 2'b00, PARK_APPROACH = 2'b01, PARK_STOP = 2'b10, PARK_DONE = 2'b11;
   localparam logic [2:0] ST_INIT = 3'd0, ST_DRIVE = 3'd1, ST_APPROACH = 3'd2, ST_STOPPING = 3'd3, ST_PARKED = 3'd4;
   localparam logic [4:0] BAR_PATTERN = 5'b11111;
   localparam logic [4:0] TURN_RST = 5'b00100;
   function automatic logic [1:0] park_code(input logic [2:0] s);
      return s == ST_APPROACH ? PARK_APPROACH : s == ST_STOPPING ? PARK_STOP : s == ST_PARKED ? PARK_DONE : PARK_DRIVE;
   endfunction
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: synchronizes the raw IR sensors, samples them on a divided tick
// and only passes a vector to turn after STABLE_CNT identical samples.
module sensor_debounce import smartpark_pkg::*; #(
   parameter int SAMPLE_DIV = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] sensor_raw,
   output logic [4:0] turn,
   output logic       tick,
   output logic       loaded
);
   localparam int DW = $clog2(SAMPLE_DIV) + 1;
   localparam int CW = $clog2(STABLE_CNT) + 1;
   logic [4:0] s1, sens_s, cand;
   logic [DW-1:0] div;
   logic [CW-1:0] cnt, cnt_n;
   logic match, load;
   assign tick = div == DW'(SAMPLE_DIV - 1);
   // a saturated count must not reload; with STABLE_CNT=1 a fresh candidate loads at once
   always_comb begin
      match = sens_s == cand;
      cnt_n = !match ? CW'(1) : cnt == CW'(STABLE_CNT) ? cnt : cnt + CW'(1);
      load = tick && cnt_n == CW'(STABLE_CNT) && (!match || cnt != CW'(STABLE_CNT));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         sens_s <= '0;
         div <= '0;
         cand <= '0;
         cnt <= '0;
         turn <= TURN_RST;
         loaded <= 1'b0;
      end else begin
         s1 <= sensor_raw;
         sens_s <= s1;
         div <= tick ? '0 : div + DW'(1);
         if (tick) begin
            cand <= sens_s;
            cnt <= cnt_n;
         end
         if (load) turn <= sens_s;
         loaded <= load;
      end
   end
endmodule

// File: rtl/line_track_filter.sv
// line_track_filter: debounced line sensors plus the parking-bar FSM.
// Define APPROACH_TIMEOUT_EN to let APPROACH fall back to DRIVE after TIMEOUT_TICKS ticks.
module line_track_filter import smartpark_pkg::*; #(
   parameter int SAMPLE_DIV    = 50000,
   parameter int STABLE_CNT    = 4,
   parameter int HOLD_TICKS    = 200,
   parameter int TIMEOUT_TICKS = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] sensor_raw,
   input  logic       restart,
   output logic [4:0] turn,
   output logic [1:0] park,
   output logic       run,
   output logic       tick
);
   localparam int HW = $clog2(HOLD_TICKS) + 1;
   logic loaded, bar_rise, hold_done, timeout;
   logic [4:0] turn_d;
   logic [2:0] state, nxt;
   logic [HW-1:0] hold;
   sensor_debounce #(.SAMPLE_DIV(SAMPLE_DIV), .STABLE_CNT(STABLE_CNT)) u_debounce (
      .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .turn(turn), .tick(tick), .loaded(loaded)
   );
   assign hold_done = tick && hold == HW'(HOLD_TICKS - 1);
`ifdef APPROACH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
   logic [TW-1:0] tmo;
   assign timeout = tick && tmo == TW'(TIMEOUT_TICKS - 1);
   always_ff @(posedge clk) begin
      if (rst) tmo <= '0;
      else tmo <= nxt != state ? '0 : tmo + TW'(state == ST_APPROACH && tick);
   end
`else
   assign timeout = TIMEOUT_TICKS < 0;
`endif
   // a bar wins over a coincident timeout; in PARKED only restart matters
   always_comb begin
      nxt = state == ST_INIT     ? (loaded ? ST_DRIVE : ST_INIT) :
            state == ST_DRIVE    ? (bar_rise ? ST_APPROACH : ST_DRIVE) :
            state == ST_APPROACH ? (bar_rise ? ST_STOPPING : timeout ? ST_DRIVE : ST_APPROACH) :
            state == ST_STOPPING ? (hold_done ? ST_PARKED : ST_STOPPING) :
                                   (restart ? ST_DRIVE : ST_PARKED);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         park <= PARK_DRIVE;
         run <= 1'b0;
         turn_d <= TURN_RST;
         bar_rise <= 1'b0;
         hold <= '0;
      end else begin
         state <= nxt;
         park <= park_code(nxt);
         run <= nxt == ST_DRIVE || nxt == ST_APPROACH || nxt == ST_STOPPING;
         turn_d <= turn;
         bar_rise <= turn == BAR_PATTERN && turn_d != BAR_PATTERN;
         hold <= nxt != state ? '0 : hold + HW'(state == ST_STOPPING && tick);
      end
   end
endmodule

// File: tb/tb_line_track_filter.sv
// tb_line_track_filter: directed table, hand sequences and random stimulus against a behavioural model.
module tb_line_track_filter;
   localparam int SD = 4, SC = 3, HT = 5, TO = 20;
`ifdef APPROACH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, restart = 1'b0;
   logic [4:0] sensor_raw = 5'b01100;
   logic [4:0] turn;
   logic [1:0] park;
   logic run, tick;
   int n_vec = 0, n_err = 0;
   bit chk_on = 1'b0;

   line_track_filter #(.SAMPLE_DIV(SD), .STABLE_CNT(SC), .HOLD_TICKS(HT), .TIMEOUT_TICKS(TO)) dut (
      .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .restart(restart),
      .turn(turn), .park(park), .run(run), .tick(tick)
   );

   always #5 clk = ~clk;

   // phases: 0 INIT, 1 DRIVE, 2 APPROACH, 3 STOPPING, 4 PARKED
   int m_cyc, m_phase, m_ticks, m_nph;
   logic [4:0] r1, r2, m_turn, m_prev, m_nt;
   bit m_new, m_bar, m_tk, m_ld;
   logic [4:0] hist[$];

   function automatic logic [1:0] exp_park(input int ph);
      return ph == 2 ? 2'b01 : ph == 3 ? 2'b10 : ph == 4 ? 2'b11 : 2'b00;
   endfunction

   function automatic bit exp_run(input int ph);
      return ph >= 1 && ph <= 3;
   endfunction

   function automatic int run_len(input logic [4:0] q[$]);
      int n = 0;
      for (int i = q.size() - 1; i >= 0 && q[i] == q[q.size() - 1]; i--) n++;
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cyc = 0; m_phase = 0; m_ticks = 0; r1 = '0; r2 = '0;
         m_turn = 5'b00100; m_prev = 5'b00100; m_new = 1'b0; m_bar = 1'b0;
         hist.delete();
      end else begin
         m_tk = (m_cyc % SD) == SD - 1;
         m_ld = 1'b0;
         m_nt = m_turn;
         if (m_tk) begin
            hist.push_back(r2);
            if (hist.size() > SC + 1) void'(hist.pop_front());
            if (run_len(hist) == SC) begin
               m_ld = 1'b1;
               m_nt = r2;
            end
         end
         m_nph = m_phase;
         case (m_phase)
            0: if (m_new) m_nph = 1;
            1: if (m_bar) m_nph = 2;
            2: if (m_bar) m_nph = 3; else if (TO_EN && m_tk && m_ticks + 1 == TO) m_nph = 1;
            3: if (m_tk && m_ticks + 1 == HT) m_nph = 4;
            default: if (restart) m_nph = 1;
         endcase
         m_ticks = (m_nph != m_phase) ? 0 : m_ticks + int'(m_tk);
         m_bar = m_turn == 5'b11111 && m_prev != 5'b11111;
         m_prev = m_turn;
         m_turn = m_nt;
         m_new = m_ld;
         m_phase = m_nph;
         r2 = r1;
         r1 = sensor_raw;
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         n_vec++;
         if (turn !== m_turn || park !== exp_park(m_phase) || run !== exp_run(m_phase) || tick !== ((m_cyc % SD) == SD - 1)) begin
            n_err++;
            if (n_err <= 30)
               $display("FAIL model t=%0t: got turn=%b park=%b run=%b tick=%b, want turn=%b park=%b run=%b tick=%b",
                        $time, turn, park, run, tick, m_turn, exp_park(m_phase), exp_run(m_phase), (m_cyc % SD) == SD - 1);
         end
      end
   end

   task automatic check_vec(input string nm, input logic [4:0] et, input logic [1:0] ep, input logic er);
      n_vec++;
      if (turn !== et || park !== ep || run !== er) begin
         n_err++;
         $display("FAIL %s: got turn=%b park=%b run=%b, want turn=%b park=%b run=%b", nm, turn, park, run, et, ep, er);
      end
   endtask

   task automatic check_tick0(input string nm);
      n_vec++;
      if (tick !== 1'b0) begin
         n_err++;
         $display("FAIL %s: got tick=%b, want tick=0", nm, tick);
      end
   endtask

   task automatic hold_pat(input logic [4:0] raw, input int ticks);
      sensor_raw = raw;
      repeat (ticks * SD) @(negedge clk);
   endtask

   typedef struct {
      logic [4:0] raw;
      int         ticks;
      logic [4:0] turn;
      logic [1:0] park;
      logic       run;
   } vec_t;
   vec_t tbl[11];
   int k;
   bit found;

   initial begin
      tbl[0]  = '{5'b01100, 2, 5'b00100, 2'b00, 1'b0};
      tbl[1]  = '{5'b01100, 1, 5'b01100, 2'b00, 1'b0};
      tbl[2]  = '{5'b01100, 1, 5'b01100, 2'b00, 1'b1};
      tbl[3]  = '{5'b00100, 4, 5'b00100, 2'b00, 1'b1};
      tbl[4]  = '{5'b00111, 2, 5'b00100, 2'b00, 1'b1};
      tbl[5]  = '{5'b00100, 4, 5'b00100, 2'b00, 1'b1};
      tbl[6]  = '{5'b11111, 4, 5'b11111, 2'b01, 1'b1};
      tbl[7]  = '{5'b00100, 4, 5'b00100, 2'b01, 1'b1};
      tbl[8]  = '{5'b11111, 4, 5'b11111, 2'b10, 1'b1};
      tbl[9]  = '{5'b11111, 3, 5'b11111, 2'b10, 1'b1};
      tbl[10] = '{5'b11111, 1, 5'b11111, 2'b11, 1'b0};
      repeat (2) @(negedge clk);
      check_vec("reset", 5'b00100, 2'b00, 1'b0);
      check_tick0("reset_tick");
      rst = 1'b0;
      chk_on = 1'b1;
      for (int i = 0; i < 11; i++) begin
         sensor_raw = tbl[i].raw;
         repeat (tbl[i].ticks * SD) @(negedge clk);
         check_vec($sformatf("tbl%0d", i), tbl[i].turn, tbl[i].park, tbl[i].run);
      end
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check_vec("restart_parked", 5'b11111, 2'b00, 1'b1);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      @(negedge clk);
      check_vec("restart_drive", 5'b11111, 2'b00, 1'b1);
      hold_pat(5'b00100, 5);
      hold_pat(5'b11111, 5);
      check_vec("approach", 5'b11111, 2'b01, 1'b1);
      hold_pat(5'b00100, 25);
      check_vec("timeout", 5'b00100, TO_EN ? 2'b00 : 2'b01, 1'b1);
      for (int s = 0; s < 120; s++) begin
         k = $urandom_range(0, 5);
         sensor_raw = k == 0 ? 5'($urandom) : k <= 2 ? 5'b11111 : k == 3 ? 5'b00100 : 5'b01100;
         repeat ($urandom_range(1, 40)) begin
            restart = $urandom_range(0, 39) == 0;
            rst = $urandom_range(0, 499) == 0;
            @(negedge clk);
         end
      end
      restart = 1'b0;
      rst = 1'b0;
      found = 1'b0;
      for (int s = 0; s < 40 && !found; s++) begin
         sensor_raw = s[0] ? 5'b11111 : 5'b00100;
         for (int c = 0; c < 20 && !found; c++) begin
            restart = m_phase == 4;
            @(negedge clk);
            found = m_phase == 3;
         end
      end
      restart = 1'b0;
      if (!found) begin
         n_vec++;
         n_err++;
         $display("FAIL reach_stopping: got no STOPPING within budget, want STOPPING");
      end else begin
         check_vec("stopping", 5'b11111, 2'b10, 1'b1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check_vec("rst_mid_stop", 5'b00100, 2'b00, 1'b0);
         check_tick0("rst_mid_stop_tick");
         hold_pat(5'b01100, 2);
         check_vec("init_after_rst", 5'b00100, 2'b00, 1'b0);
         hold_pat(5'b01100, 2);
         check_vec("drive_after_rst", 5'b01100, 2'b00, 1'b1);
      end
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
